pe_seq_ctrl: RTL

PE_SEQ_CTRL -- requirements
Module: pe_seq_ctrl

---
 rtl/pe_seq_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/pe_seq_ctrl.sv
// Sequencer for a 256-point NTT/INTT butterfly engine.
// Issues coefficient-pair reads and twiddle indices layer by layer. It drains
// the PE pipeline between layers so that a read never overtakes a pending
// write-back of the previous layer. It also replays each issue as a write-back
// strobe WB_LAT cycles later.
module pe_seq_ctrl #(
    parameter int RD_LAT = 1,
    parameter int PE_LAT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       mode_i,
    input  logic       stall_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       rd_en_o,
    output logic [7:0] rd_addr_a_o,
    output logic [7:0] rd_addr_b_o,
    output logic [6:0] zeta_addr_o,
    output logic       pe_valid_o,
    output logic [3:0] pe_ctrl_o,
    output logic       wr_en_o,
    output logic [7:0] wr_addr_a_o,
    output logic [7:0] wr_addr_b_o
);

    localparam int WB_LAT = RD_LAT + PE_LAT;
    localparam int DW     = $clog2(WB_LAT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state_reg, state_next;
    logic [6:0]      n_reg, n_next;
    logic [2:0]      layer_reg, layer_next;
    logic            mode_reg, mode_next;
    logic [DW-1:0]   drain_reg, drain_next;
    logic            issue;

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            n_reg     <= '0;
            layer_reg <= '0;
            mode_reg  <= 1'b0;
            drain_reg <= '0;
        end else begin
            state_reg <= state_next;
            n_reg     <= n_next;
            layer_reg <= layer_next;
            mode_reg  <= mode_next;
            drain_reg <= drain_next;
        end
    end

    // Next-state logic: issue 128 butterflies per layer, then drain WB_LAT cycles.
    always_comb begin
        state_next = state_reg;
        n_next     = n_reg;
        layer_next = layer_reg;
        mode_next  = mode_reg;
        drain_next = drain_reg;
        issue      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    state_next = RUN;
                    mode_next  = mode_i;
                    layer_next = '0;
                    n_next     = '0;
                end
            end
            RUN: begin
                if (!stall_i) begin
                    issue  = 1'b1;
                    n_next = n_reg + 7'd1;
                    if (n_reg == 7'd127) begin
                        state_next = DRAIN;
                        drain_next = '0;
                    end
                end
            end
            DRAIN: begin
                if (drain_reg == DW'(WB_LAT - 1)) begin
                    if (layer_reg == 3'd6) begin
                        state_next = DONE;
                    end else begin
                        state_next = RUN;
                        layer_next = layer_reg + 3'd1;
                        n_next     = '0;
                    end
                end else begin
                    drain_next = drain_reg + DW'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Address generation. With L = 2^shift, the pair index a is n with a zero
    // bit inserted at position shift; b sets that bit.
    logic [2:0] shift;
    logic [3:0] shift_p1;
    logic [7:0] n_ext;
    logic [7:0] group8;
    logic [6:0] group7;
    logic [7:0] len;
    logic [7:0] addr_a;
    logic [8:0] zbase;
    logic [6:0] zeta_calc;

    // Butterfly addresses and twiddle index for the current n and layer.
    always_comb begin
        shift     = mode_reg ? (layer_reg + 3'd1) : (3'd7 - layer_reg);
        shift_p1  = {1'b0, shift} + 4'd1;
        n_ext     = {1'b0, n_reg};
        group8    = n_ext >> shift;
        group7    = n_reg >> shift;
        len       = 8'd1 << shift;
        addr_a    = (group8 << shift_p1) | (n_ext & (len - 8'd1));
        zbase     = mode_reg ? ((9'd256 >> shift) - 9'd1) : (9'd128 >> shift);
        zeta_calc = mode_reg ? (7'(zbase) - group7) : (7'(zbase) + group7);
    end

    assign rd_en_o     = issue;
    assign rd_addr_a_o = issue ? addr_a : 8'd0;
    assign rd_addr_b_o = issue ? (addr_a | len) : 8'd0;
    assign zeta_addr_o = issue ? zeta_calc : 7'd0;
    assign busy_o      = (state_reg != IDLE);
    assign done_o      = (state_reg == DONE);
    assign pe_ctrl_o   = busy_o ? {3'b000, mode_reg} : 4'b0000;

    // PE valid: issue strobe delayed by the memory read latency.
    logic [RD_LAT-1:0] vld_pipe;

    // First stage of the read-latency delay line.
    always_ff @(posedge clk) begin
        if (rst) vld_pipe[0] <= 1'b0;
        else     vld_pipe[0] <= issue;
    end

    generate
        for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_vld
            // Remaining read-latency stages.
            always_ff @(posedge clk) begin
                if (rst) vld_pipe[gi] <= 1'b0;
                else     vld_pipe[gi] <= vld_pipe[gi-1];
            end
        end
    endgenerate

    assign pe_valid_o = vld_pipe[RD_LAT-1];

    // Write-back: {strobe, addr_a, addr_b} delayed by read plus PE latency.
    // Reset flushes it so an aborted operation never writes.
    logic [16:0] wb_pipe [WB_LAT];

    generate
        for (genvar gi = 0; gi < WB_LAT; gi++) begin : g_wb
            if (gi == 0) begin : g_head
                // Capture the current issue.
                always_ff @(posedge clk) begin
                    if (rst) wb_pipe[gi] <= '0;
                    else     wb_pipe[gi] <= {rd_en_o, rd_addr_a_o, rd_addr_b_o};
                end
            end else begin : g_body
                // Shift toward the write port.
                always_ff @(posedge clk) begin
                    if (rst) wb_pipe[gi] <= '0;
                    else     wb_pipe[gi] <= wb_pipe[gi-1];
                end
            end
        end
    endgenerate

    assign wr_en_o     = wb_pipe[WB_LAT-1][16];
    assign wr_addr_a_o = wb_pipe[WB_LAT-1][15:8];
    assign wr_addr_b_o = wb_pipe[WB_LAT-1][7:0];

endmodule
